// File: rtl/preamble_pkg.sv
// preamble_pkg -- shared types and helpers for preamble_tx.
//   state_t   : FSM state encoding. GUARD exists only when PREAMBLE_TX_GUARD_EN
//               is defined.
//   LFSR_LEN  : LFSR register length in bits.
//   LFSR_TAPS : feedback tap mask for x^16+x^14+x^13+x^11+1. The register
//               shifts right and the new bit enters at the MSB, so the
//               polynomial taps land on bits 0, 2, 3 and 5.
//   qpsk_map  : maps one LFSR bit to a +AMP / -AMP two's-complement sample.
package preamble_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRE     = 2'd1,
`ifdef PREAMBLE_TX_GUARD_EN
    ST_GUARD   = 2'd2,
`endif
    ST_PAYLOAD = 2'd3
  } state_t;

  localparam int                  LFSR_LEN  = 16;
  localparam logic [LFSR_LEN-1:0] LFSR_TAPS = 16'h002D;

  // A set bit selects the negative amplitude. The caller truncates the
  // 32-bit result to its sample width.
  function automatic logic [31:0] qpsk_map(input logic bit_v, input logic [31:0] amp);
    logic [31:0] res;
    if (bit_v) begin
      res = 32'd0 - amp;
    end else begin
      res = amp;
    end
    return res;
  endfunction

endpackage

// File: rtl/preamble_lfsr.sv
// preamble_lfsr -- 16-bit Fibonacci LFSR that produces the preamble symbols.
//   clk, reset_n : clock, asynchronous active-low reset (the reset loads SEED)
//   load         : reload SEED. Takes priority over step.
//   step         : advance the register by one position
//   state        : current register contents
module preamble_lfsr
  import preamble_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                step,
  output logic [LFSR_LEN-1:0] state
);

  logic [LFSR_LEN-1:0] state_r;
  logic                feedback_s;

  // The feedback bit is the parity of the tapped bits.
  always_comb begin
    feedback_s = ^(state_r & LFSR_TAPS);
  end

  // Shift register with a reload path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= SEED;
    end else if (step) begin
      state_r <= {feedback_s, state_r[LFSR_LEN-1:1]};
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/preamble_tx.sv
// preamble_tx -- emits an NREP-times repeated QPSK pseudo-random preamble.
// Each symbol is held for INTERP_RATE beats. After the preamble the block
// optionally emits zero guard beats, then passes a payload stream through
// until the payload's tlast beat.
//   clk, reset_n       : clock, asynchronous active-low reset
//   clear              : synchronous return to IDLE. Drops any in-flight beat.
//   start              : single-cycle request. Honoured only in IDLE.
//   in_*               : payload AXI-style stream (in_tready is an output)
//   out_*              : transmit AXI-style stream (out_tready is an input)
//   busy, pre_active   : status flags (not IDLE / in PRE)
// Build option: defining PREAMBLE_TX_GUARD_EN adds the GUARD state, which
// emits GUARD_LEN zero beats between the preamble and the payload.
module preamble_tx
  import preamble_pkg::*;
#(
  parameter int                             DATA_WIDTH  = 16,
  parameter int                             MAX_LEN     = 4095,
  parameter logic [$clog2(MAX_LEN+1)-1:0]   LEN         = 4092,
  parameter int                             INTERP_RATE = 64,
  parameter int                             NREP        = 2,
  parameter logic [DATA_WIDTH-1:0]          AMP         = 8192,
  parameter logic [LFSR_LEN-1:0]            SEED        = 16'hACE1
`ifdef PREAMBLE_TX_GUARD_EN
  , parameter int                           GUARD_LEN   = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  in_tvalid,
  input  logic                  in_tlast,
  input  logic [DATA_WIDTH-1:0] in_itdata,
  input  logic [DATA_WIDTH-1:0] in_qtdata,
  output logic                  in_tready,
  output logic                  out_tvalid,
  output logic                  out_tlast,
  output logic [DATA_WIDTH-1:0] out_itdata,
  output logic [DATA_WIDTH-1:0] out_qtdata,
  input  logic                  out_tready,
  output logic                  busy,
  output logic                  pre_active
);

  localparam int                LW       = $clog2(MAX_LEN + 1);
  localparam int                RW       = (NREP > 1) ? $clog2(NREP) : 1;
  localparam logic [7:0]        IR_LAST  = 8'(INTERP_RATE - 1);
  localparam logic [LW-1:0]     LEN_LAST = LEN - 1'b1;
  localparam logic [RW-1:0]     REP_LAST = RW'(NREP - 1);
`ifdef PREAMBLE_TX_GUARD_EN
  localparam int                GW       = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  localparam logic [GW-1:0]     G_LAST   = GW'(GUARD_LEN - 1);
  localparam state_t            AFTER_PRE = ST_GUARD;
`else
  localparam state_t            AFTER_PRE = ST_PAYLOAD;
`endif

  generate
    if (LEN == 0 || INTERP_RATE < 1 || INTERP_RATE > 255 || NREP < 1) begin : g_bad_param
      $error("preamble_tx: LEN and NREP must be non-zero and INTERP_RATE in 1..255");
    end
`ifdef PREAMBLE_TX_GUARD_EN
    if (GUARD_LEN < 1) begin : g_bad_guard
      $error("preamble_tx: GUARD_LEN must be non-zero");
    end
`endif
  endgenerate

  state_t                  state_r, state_s;
  logic [7:0]              beat_cnt_r, beat_s;
  logic [LW-1:0]           sym_cnt_r, sym_s;
  logic [RW-1:0]           rep_cnt_r, rep_s;
`ifdef PREAMBLE_TX_GUARD_EN
  logic [GW-1:0]           guard_cnt_r, guard_s;
`endif
  logic                    lfsr_load_s, lfsr_step_s;
  logic [LFSR_LEN-1:0]     lfsr_state_s;
  logic                    lfsr_unused_s;
  logic                    out_free_s, in_tready_s, in_fire_s, gen_pre_s, pre_last_s;
  logic [DATA_WIDTH-1:0]   sym_i_s, sym_q_s;
  logic                    out_tvalid_r, out_tlast_r, busy_r, pre_active_r;
  logic [DATA_WIDTH-1:0]   out_i_r, out_q_r;

  preamble_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load_s),
    .step    (lfsr_step_s),
    .state   (lfsr_state_s)
  );

  // Only the two low LFSR bits form a symbol. The upper bits only feed the shift.
  assign lfsr_unused_s = ^lfsr_state_s[LFSR_LEN-1:2];

  // Handshake qualifiers and the current symbol value.
  always_comb begin
    out_free_s  = ~out_tvalid_r | out_tready;
    in_tready_s = (state_r == ST_PAYLOAD) & out_free_s;
    in_fire_s   = in_tvalid & in_tready_s;
    // The first preamble beat is produced in the same cycle that start is seen.
    gen_pre_s   = out_free_s & ~clear &
                  ((state_r == ST_PRE) | ((state_r == ST_IDLE) & start));
    pre_last_s  = (beat_cnt_r == IR_LAST) & (sym_cnt_r == LEN_LAST) & (rep_cnt_r == REP_LAST);
    sym_i_s     = DATA_WIDTH'(qpsk_map(lfsr_state_s[0], 32'(AMP)));
    sym_q_s     = DATA_WIDTH'(qpsk_map(lfsr_state_s[1], 32'(AMP)));
  end

  // Next state, the beat/symbol/repetition counters and LFSR control.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_cnt_r;
    sym_s       = sym_cnt_r;
    rep_s       = rep_cnt_r;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
`ifdef PREAMBLE_TX_GUARD_EN
    guard_s     = guard_cnt_r;
`endif
    if (clear) begin
      state_s     = ST_IDLE;
      beat_s      = '0;
      sym_s       = '0;
      rep_s       = '0;
      lfsr_load_s = 1'b1;
`ifdef PREAMBLE_TX_GUARD_EN
      guard_s     = '0;
`endif
    end else begin
      if (gen_pre_s) begin
        if (beat_cnt_r == IR_LAST) begin
          beat_s = '0;
          if (sym_cnt_r == LEN_LAST) begin
            // A repetition ends here: reload SEED so the next one repeats it.
            sym_s       = '0;
            lfsr_load_s = 1'b1;
            if (rep_cnt_r == REP_LAST) begin
              rep_s = '0;
            end else begin
              rep_s = rep_cnt_r + 1'b1;
            end
          end else begin
            sym_s       = sym_cnt_r + 1'b1;
            lfsr_step_s = 1'b1;
          end
        end else begin
          beat_s = beat_cnt_r + 8'd1;
        end
      end else begin
        beat_s = beat_cnt_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = (gen_pre_s && pre_last_s) ? AFTER_PRE : ST_PRE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PRE: begin
          if (gen_pre_s && pre_last_s) begin
            state_s = AFTER_PRE;
          end else begin
            state_s = ST_PRE;
          end
        end
`ifdef PREAMBLE_TX_GUARD_EN
        ST_GUARD: begin
          if (out_free_s) begin
            if (guard_cnt_r == G_LAST) begin
              guard_s = '0;
              state_s = ST_PAYLOAD;
            end else begin
              guard_s = guard_cnt_r + 1'b1;
              state_s = ST_GUARD;
            end
          end else begin
            state_s = ST_GUARD;
          end
        end
`endif
        ST_PAYLOAD: begin
          if (in_fire_s && in_tlast) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and status flags. The flags are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= '0;
      sym_cnt_r    <= '0;
      rep_cnt_r    <= '0;
`ifdef PREAMBLE_TX_GUARD_EN
      guard_cnt_r  <= '0;
`endif
      busy_r       <= 1'b0;
      pre_active_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      beat_cnt_r   <= beat_s;
      sym_cnt_r    <= sym_s;
      rep_cnt_r    <= rep_s;
`ifdef PREAMBLE_TX_GUARD_EN
      guard_cnt_r  <= guard_s;
`endif
      busy_r       <= (state_s != ST_IDLE);
      pre_active_r <= (state_s == ST_PRE);
    end
  end

  // Output register. It takes a new beat whenever it is empty or being drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_tvalid_r <= 1'b0;
      out_tlast_r  <= 1'b0;
      out_i_r      <= '0;
      out_q_r      <= '0;
    end else if (clear) begin
      out_tvalid_r <= 1'b0;
      out_tlast_r  <= 1'b0;
      out_i_r      <= '0;
      out_q_r      <= '0;
    end else if (out_free_s) begin
      case (state_r)
        ST_IDLE, ST_PRE: begin
          out_tvalid_r <= gen_pre_s;
          out_tlast_r  <= 1'b0;
          out_i_r      <= gen_pre_s ? sym_i_s : out_i_r;
          out_q_r      <= gen_pre_s ? sym_q_s : out_q_r;
        end
`ifdef PREAMBLE_TX_GUARD_EN
        ST_GUARD: begin
          out_tvalid_r <= 1'b1;
          out_tlast_r  <= 1'b0;
          out_i_r      <= '0;
          out_q_r      <= '0;
        end
`endif
        ST_PAYLOAD: begin
          out_tvalid_r <= in_tvalid;
          out_tlast_r  <= in_tvalid & in_tlast;
          out_i_r      <= in_tvalid ? in_itdata : out_i_r;
          out_q_r      <= in_tvalid ? in_qtdata : out_q_r;
        end
        default: begin
          out_tvalid_r <= 1'b0;
          out_tlast_r  <= 1'b0;
        end
      endcase
    end else begin
      out_tvalid_r <= out_tvalid_r;
    end
  end

  assign in_tready  = in_tready_s;
  assign out_tvalid = out_tvalid_r;
  assign out_tlast  = out_tlast_r;
  assign out_itdata = out_i_r;
  assign out_qtdata = out_q_r;
  assign busy       = busy_r;
  assign pre_active = pre_active_r;

endmodule

// File: tb/tb_preamble_tx.sv
// tb_preamble_tx -- self-checking bench for preamble_tx. Small configuration:
// LEN=4, INTERP_RATE=2, NREP=2, AMP=100. Expected beats come from a local
// LFSR model and go into a scoreboard queue, which the output monitor
// drains one beat per accepted handshake.
module tb_preamble_tx;

  typedef struct packed {
    logic        last;
    logic [15:0] i;
    logic [15:0] q;
  } beat_t;

  typedef struct {
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        in_last;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    logic        exp_last;
  } vec_t;

`ifdef PREAMBLE_TX_GUARD_EN
  localparam int FRAME_BEATS = 21;
`else
  localparam int FRAME_BEATS = 16;
`endif

  logic        clk = 1'b0;
  logic        reset_n, clear, start;
  logic        in_tvalid, in_tlast, in_tready;
  logic [15:0] in_itdata, in_qtdata;
  logic        out_tvalid, out_tlast, out_tready;
  logic [15:0] out_itdata, out_qtdata;
  logic        busy, pre_active;

  beat_t exp_q[$];
  vec_t  pay_tbl[3];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_beats  = 0;
  bit    mon_en   = 1'b0;
  bit    stab_en  = 1'b0;

  preamble_tx #(
    .DATA_WIDTH (16),
    .LEN        (12'd4),
    .INTERP_RATE(2),
    .NREP       (2),
    .AMP        (16'd100),
    .SEED       (16'hACE1)
`ifdef PREAMBLE_TX_GUARD_EN
    , .GUARD_LEN(5)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .start      (start),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_itdata  (in_itdata),
    .in_qtdata  (in_qtdata),
    .in_tready  (in_tready),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_itdata (out_itdata),
    .out_qtdata (out_qtdata),
    .out_tready (out_tready),
    .busy       (busy),
    .pre_active (pre_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish on its own");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // x^16+x^14+x^13+x^11+1, shifting right with the new bit entering at bit 15
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | ({15'd0, fb} << 15);
  endfunction

  function automatic logic [15:0] amp_of(input logic neg);
    return neg ? 16'hFF9C : 16'h0064;
  endfunction

  task automatic push_frame();
    logic [15:0] s;
    beat_t       b;
    for (int r = 0; r < 2; r++) begin
      s = 16'hACE1;
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < 2; j++) begin
          b.last = 1'b0;
          b.i    = amp_of(s[0]);
          b.q    = amp_of(s[1]);
          exp_q.push_back(b);
        end
        s = lfsr_next(s);
      end
    end
`ifdef PREAMBLE_TX_GUARD_EN
    for (int g = 0; g < 5; g++) begin
      b = '0;
      exp_q.push_back(b);
    end
`endif
  endtask

  // Output monitor: scoreboard compare plus a hold check while stalled.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_d = 32'd0;
  always @(negedge clk) begin
    beat_t e;
    if (mon_en && out_tvalid && out_tready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(out_tvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({out_tlast, out_itdata, out_qtdata}), 64'(e));
      end
    end
    if (stab_en && prev_v && !prev_r) begin
      check("stall_hold", 64'({out_tvalid, out_itdata, out_qtdata}), 64'({1'b1, prev_d}));
    end
    prev_v = out_tvalid;
    prev_r = out_tready;
    prev_d = {out_itdata, out_qtdata};
  end

  task automatic run_payload();
    bit    got;
    beat_t b;
    for (int k = 0; k < 3; k++) begin
      in_itdata = pay_tbl[k].in_i;
      in_qtdata = pay_tbl[k].in_q;
      in_tlast  = pay_tbl[k].in_last;
      in_tvalid = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (in_tready) begin
          b.last = pay_tbl[k].exp_last;
          b.i    = pay_tbl[k].exp_i;
          b.q    = pay_tbl[k].exp_q;
          exp_q.push_back(b);
          got = 1'b1;
        end
        @(posedge clk); #1;
      end
      check("pay_accept", 64'(got), 64'(1));
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic run_frame(input bit toggle, input bit repulse);
    int cyc;
    out_tready = 1'b1;
    n_beats    = 0;
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_valid", 64'(out_tvalid), 64'(1));
    check("busy_pre", 64'(busy), 64'(1));
    check("pre_active", 64'(pre_active), 64'(1));
    check("in_tready_pre", 64'(in_tready), 64'(0));
    stab_en = toggle;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      if (toggle) out_tready = ~out_tready;
      start = (repulse && cyc == 4) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start      = 1'b0;
    stab_en    = 1'b0;
    out_tready = 1'b1;
    check("pre_drain", 64'(exp_q.size()), 64'(0));
    check("pre_beats", 64'(n_beats), 64'(FRAME_BEATS));
    repeat (2) @(posedge clk);
    #1;
    check("gap_valid", 64'(out_tvalid), 64'(0));
    check("in_tready_pay", 64'(in_tready), 64'(1));
    run_payload();
    repeat (3) @(posedge clk);
    #1;
    check("pay_drain", 64'(exp_q.size()), 64'(0));
    check("busy_done", 64'(busy), 64'(0));
  endtask

  initial begin
    pay_tbl[0] = '{16'd1, 16'd2, 1'b0, 16'd1, 16'd2, 1'b0};
    pay_tbl[1] = '{16'd3, 16'd4, 1'b0, 16'd3, 16'd4, 1'b0};
    pay_tbl[2] = '{16'd5, 16'd6, 1'b1, 16'd5, 16'd6, 1'b1};

    reset_n = 1'b0; clear = 1'b0; start = 1'b0;
    in_tvalid = 1'b0; in_tlast = 1'b0; in_itdata = 16'd0; in_qtdata = 16'd0;
    out_tready = 1'b1;
    #1;
    check("rst_outputs", 64'({out_tvalid, out_tlast, out_itdata, out_qtdata, in_tready, busy, pre_active}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'(0));
    mon_en = 1'b1;

    run_frame(1'b0, 1'b0);   // plain frame
    run_frame(1'b1, 1'b0);   // out_tready toggling 1010
    run_frame(1'b0, 1'b1);   // start re-pulsed mid-preamble

    // clear partway through the preamble
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    check("clr_valid", 64'(out_tvalid), 64'(0));
    check("clr_busy", 64'({busy, pre_active}), 64'(0));
    // clear wins over a simultaneous start
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_prio", 64'({out_tvalid, busy}), 64'(0));
    run_frame(1'b0, 1'b0);   // must restart from SEED

    // asynchronous reset partway through the preamble
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    exp_q.delete();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", 64'({out_tvalid, out_tlast, out_itdata, out_qtdata, in_tready, busy, pre_active}), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    run_frame(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
